// File: rtl/drfm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : drfm_pkg
// Brief    : Shared widths, defaults and state type for the PWM sample feeder.
// Revision : 1.0
// ============================================================================
package drfm_pkg;

  localparam int SAMPLE_W   = 8;
  localparam int PWM_PERIOD = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RECV = 2'd2
  } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_sample_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_sample_feeder_if
// Brief    : SDRAM read-port and PWM-side signals of the sample feeder.
// Revision : 1.0
// ============================================================================
interface pwm_sample_feeder_if
  import drfm_pkg::*;
#(
  parameter int DEPTH = 16
) ();

  logic                    enable;
  logic                    rd_req;
  logic                    rd_ack;
  logic                    rd_valid;
  logic [SAMPLE_W-1:0]     rd_data;
  logic [SAMPLE_W-1:0]     sample;
  logic                    sample_strobe;
  logic                    underflow;
  logic                    overflow;
  logic [$clog2(DEPTH):0]  level;

  // slave: the feeder itself; master: controller / PWM environment
  modport slave (
    input  enable, rd_ack, rd_valid, rd_data,
    output rd_req, sample, sample_strobe, underflow, overflow, level
  );

  modport master (
    output enable, rd_ack, rd_valid, rd_data,
    input  rd_req, sample, sample_strobe, underflow, overflow, level
  );

endinterface
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sample_fifo
// Brief    : Synchronous sample FIFO with registered read data on pop.
// Revision : 1.0
// ============================================================================
module sample_fifo
  import drfm_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  wire                       clk,
  input  wire                       rst_n,
  input  wire                       i_push,
  input  wire  [SAMPLE_W-1:0]       i_din,
  input  wire                       i_pop,
  output logic [SAMPLE_W-1:0]       o_dout,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_level
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_lw = c_aw + 1;

  logic [SAMPLE_W-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]     r_wr_ptr;
  logic [c_aw-1:0]     r_rd_ptr;
  logic [c_lw-1:0]     r_level;
  logic [SAMPLE_W-1:0] r_dout;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == c_lw'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_dout   <= r_mem[r_rd_ptr];
      end
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  assign o_dout  = r_dout;
  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/pwm_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : pwm_sample_feeder
// Brief    : Burst-refilled sample buffer feeding one sample per PWM period.
// Revision : 1.0
// ============================================================================
module pwm_sample_feeder
  import drfm_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 8,
  parameter int PERIOD    = PWM_PERIOD
) (
  input  wire                 CLK,
  input  wire                 reset_n,
  pwm_sample_feeder_if.slave  bus
);

  localparam int c_cnt_w  = $clog2(PERIOD);
  localparam int c_lvl_w  = $clog2(DEPTH) + 1;
  localparam int c_beat_w = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [c_lvl_w-1:0] c_req_thresh = c_lvl_w'(DEPTH - BURST_LEN);

  feeder_state_t       r_state;
  feeder_state_t       w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_beat_w-1:0] r_beats;
  logic                r_strobe;
  logic                r_underflow;
  logic                r_overflow;
  logic                w_bnd;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_rd_req;
  logic                w_beat_last;
  logic [c_lvl_w-1:0]  w_level;
  logic [SAMPLE_W-1:0] w_sample;

  assign w_bnd       = bus.enable && (r_cnt == c_cnt_w'(PERIOD - 1));
  assign w_pop       = w_bnd && !w_empty;
  assign w_beat_last = bus.rd_valid && (r_beats == c_beat_w'(BURST_LEN - 1));

  // The FIFO read register is the duty sample: it updates on the wrap edge.
  sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (reset_n),
    .i_push  (bus.rd_valid),
    .i_din   (bus.rd_data),
    .i_pop   (w_pop),
    .o_dout  (w_sample),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_strobe    <= 1'b0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_cnt       <= (!bus.enable || w_bnd) ? '0 : r_cnt + 1'b1;
      r_strobe    <= w_pop;
      r_underflow <= r_underflow | (w_bnd & w_empty);
      r_overflow  <= r_overflow | (bus.rd_valid & w_full & ~w_pop);
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_beats <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == RECV && bus.rd_valid) begin
        r_beats <= w_beat_last ? '0 : r_beats + 1'b1;
      end
    end
  end

  // Threshold only checked in IDLE, so a single burst is outstanding at most.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_req    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_level <= c_req_thresh) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        w_rd_req = 1'b1;
        if (bus.rd_ack) begin
          w_state_nxt = RECV;
        end
      end
      RECV: begin
        if (w_beat_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.rd_req        = w_rd_req;
  assign bus.sample        = w_sample;
  assign bus.sample_strobe = r_strobe;
  assign bus.underflow     = r_underflow;
  assign bus.overflow      = r_overflow;
  assign bus.level         = w_level;

endmodule
`default_nettype wire

// File: tb/tb_pwm_sample_feeder.sv
`default_nettype none
// Bench for pwm_sample_feeder: queue-based reference model, strobe scoreboard,
// scripted scenarios followed by randomized enable/beat traffic.
module tb_pwm_sample_feeder;
  import drfm_pkg::*;

  localparam int DEPTH     = 16;
  localparam int BURST_LEN = 8;
  localparam int PERIOD    = 256;

  logic CLK     = 1'b0;
  logic reset_n = 1'b0;
  always #5 CLK = ~CLK;

  pwm_sample_feeder_if #(.DEPTH(DEPTH)) bus ();

  pwm_sample_feeder #(
    .DEPTH     (DEPTH),
    .BURST_LEN (BURST_LEN),
    .PERIOD    (PERIOD)
  ) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic       ctl_valid = 1'b0;
  logic       inj_valid = 1'b0;
  logic [7:0] ctl_data  = 8'h00;
  logic [7:0] inj_data  = 8'h00;
  assign bus.rd_valid = ctl_valid | inj_valid;
  assign bus.rd_data  = inj_valid ? inj_data : ctl_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int cyc; logic [7:0] val; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] mq[$];
  int         cyc = 0;
  int         m_cnt = 0;
  int         m_left = 0;
  bit         m_req = 0, m_under = 0, m_over = 0;
  logic [7:0] m_sample = 8'h00;

  always @(posedge CLK or negedge reset_n) begin
    int lvl_pre;
    bit bnd, pop, idle;
    if (!reset_n) begin
      mq.delete();
      exp_q.delete();
      m_cnt = 0; m_left = 0; m_req = 0; m_under = 0; m_over = 0; m_sample = 8'h00;
    end else begin
      cyc++;
      lvl_pre = mq.size();
      bnd  = bus.enable && (m_cnt == PERIOD - 1);
      pop  = bnd && (lvl_pre > 0);
      idle = !m_req && (m_left == 0);
      if (bnd && lvl_pre == 0) m_under = 1;
      if (pop) begin
        m_sample = mq.pop_front();
        exp_q.push_back('{cyc, m_sample});
      end
      if (bus.rd_valid) begin
        if (mq.size() < DEPTH) mq.push_back(bus.rd_data);
        else m_over = 1;
        if (m_left > 0) m_left--;
      end
      if (m_req && bus.rd_ack) begin
        m_req = 0;
        m_left = BURST_LEN;
      end else if (idle && lvl_pre <= DEPTH - BURST_LEN) begin
        m_req = 1;
      end
      m_cnt = (!bus.enable || bnd) ? 0 : m_cnt + 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    if (reset_n) begin
      chk("rd_req", {31'd0, bus.rd_req}, {31'd0, m_req});
      chk("level", 32'(bus.level), 32'(mq.size()));
      chk("underflow", {31'd0, bus.underflow}, {31'd0, m_under});
      chk("overflow", {31'd0, bus.overflow}, {31'd0, m_over});
      chk("sample", 32'(bus.sample), 32'(m_sample));
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL strobe_missing actual=none required=strobe@cycle%0d now=%0d", exp_q[0].cyc, cyc);
        exp_q.delete(0);
      end
      if (bus.sample_strobe) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL strobe_unexpected actual=1 required=0 cycle=%0d", cyc);
        end else begin
          chk("strobe_cycle", 32'(cyc), 32'(exp_q[0].cyc));
          chk("strobe_sample", 32'(bus.sample), 32'(exp_q[0].val));
          exp_q.delete(0);
        end
      end
    end
  end

  // ---------------- SDRAM controller stand-in ----------------
  int         ctl_mode = 1;   // 0: never ack, 1: fixed latency/incrementing data, 2: random
  int         ctl_st = 0;
  int         ctl_dly = 0;
  int         ctl_beats = 0;
  logic [7:0] seq = 8'h10;

  initial begin
    bus.rd_ack = 1'b0;
    forever begin
      @(negedge CLK);
      bus.rd_ack = 1'b0;
      ctl_valid  = 1'b0;
      if (!reset_n) begin
        ctl_st = 0;
      end else begin
        case (ctl_st)
          0: if (bus.rd_req && ctl_mode != 0) begin
               ctl_dly = (ctl_mode == 1) ? 2 : int'($urandom_range(0, 4));
               ctl_st  = 1;
             end
          1: if (ctl_dly == 0) begin
               bus.rd_ack = 1'b1;
               ctl_beats  = BURST_LEN;
               ctl_st     = 2;
             end else begin
               ctl_dly--;
             end
          2: if (ctl_mode == 1 || $urandom_range(0, 3) != 0) begin
               ctl_valid = 1'b1;
               ctl_data  = (ctl_mode == 1) ? seq : 8'($urandom);
               seq++;
               ctl_beats--;
               if (ctl_beats == 0) ctl_st = 0;
             end
          default: ctl_st = 0;
        endcase
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk_reset_vals(input string nm);
    chk({nm, "_rd_req"}, {31'd0, bus.rd_req}, 32'd0);
    chk({nm, "_sample"}, 32'(bus.sample), 32'd0);
    chk({nm, "_strobe"}, {31'd0, bus.sample_strobe}, 32'd0);
    chk({nm, "_underflow"}, {31'd0, bus.underflow}, 32'd0);
    chk({nm, "_overflow"}, {31'd0, bus.overflow}, 32'd0);
    chk({nm, "_level"}, 32'(bus.level), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 reset_n = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    reset_n = 1'b1;
  endtask

  task automatic wait_cnt(input int target);
    bit seen = 0;
    for (int i = 0; i < 2 * PERIOD && !seen; i++) begin
      @(negedge CLK);
      if (m_cnt == target) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_cnt actual=timeout required=count%0d", target);
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int  t_en;
    bit  seen;
    int  n;
    bus.enable = 1'b0;
    ctl_mode   = 1;
    repeat (3) @(negedge CLK);
    chk_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge CLK);
    chk("p1_req_after_release", {31'd0, bus.rd_req}, 32'd1);
    repeat (80) @(negedge CLK);
    chk("p1_level_full", 32'(bus.level), 32'(DEPTH));
    chk("p1_no_req", {31'd0, bus.rd_req}, 32'd0);

    // Prefilled 0x10..0x1F: five periods pop 0x10..0x14
    bus.enable = 1'b1;
    repeat (5 * PERIOD + 10) @(negedge CLK);
    chk("p2_sample", 32'(bus.sample), 32'h14);

    // No data ever returned: first boundary underflows
    bus.enable = 1'b0;
    ctl_mode   = 0;
    do_reset();
    bus.enable = 1'b1;
    repeat (300) @(negedge CLK);
    chk("p3_underflow", {31'd0, bus.underflow}, 32'd1);
    chk("p3_sample", 32'(bus.sample), 32'd0);

    // Push+pop at full, then push at full without pop
    bus.enable = 1'b0;
    ctl_mode   = 1;
    do_reset();
    repeat (80) @(negedge CLK);
    ctl_mode   = 0;
    bus.enable = 1'b1;
    wait_cnt(PERIOD - 1);
    inj_valid = 1'b1; inj_data = 8'hAA;
    @(negedge CLK);
    inj_valid = 1'b0;
    chk("p4_level_pushpop", 32'(bus.level), 32'(DEPTH));
    chk("p4_no_overflow", {31'd0, bus.overflow}, 32'd0);
    inj_valid = 1'b1; inj_data = 8'h55;
    @(negedge CLK);
    inj_valid = 1'b0;
    chk("p4_overflow", {31'd0, bus.overflow}, 32'd1);
    chk("p4_level_full", 32'(bus.level), 32'(DEPTH));

    // Asynchronous reset three beats into a burst
    bus.enable = 1'b0;
    ctl_mode   = 1;
    do_reset();
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      #1;
      if (ctl_st == 2 && ctl_beats == BURST_LEN - 3) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL p5_wait_beats actual=timeout required=3beats");
    end
    #1 reset_n = 1'b0;
    #1 chk_reset_vals("p5_async");
    @(negedge CLK);
    @(negedge CLK);
    reset_n = 1'b1;
    chk("p5_release_idle", {31'd0, bus.rd_req}, 32'd0);
    @(negedge CLK);
    chk("p5_req", {31'd0, bus.rd_req}, 32'd1);

    // Disable at count 100; next strobe a full period after re-enable
    ctl_mode = 2;
    repeat (60) @(negedge CLK);
    bus.enable = 1'b1;
    wait_cnt(100);
    bus.enable = 1'b0;
    repeat (400) @(negedge CLK);
    bus.enable = 1'b1;
    t_en = cyc;
    seen = 0;
    for (int i = 0; i < 2 * PERIOD && !seen; i++) begin
      @(negedge CLK);
      if (bus.sample_strobe) seen = 1;
    end
    chk("p6_strobe_gap", 32'(cyc - t_en), 32'(PERIOD));

    // Randomized enable and stray beats
    for (int s = 0; s < 12; s++) begin
      bus.enable = ($urandom_range(0, 4) != 0);
      n = int'($urandom_range(50, 700));
      for (int i = 0; i < n; i++) begin
        @(negedge CLK);
        inj_valid = ($urandom_range(0, 40) == 0);
        inj_data  = 8'($urandom);
      end
    end
    inj_valid = 1'b0;
    repeat (5) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
